// File: rtl/adder_share_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adder_share_ctrl: round-robin arbiter that time-shares one add/sub unit.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module adder_share_ctrl #(
  parameter int N_REQ      = 4,
  parameter int WIDTH      = 8,
  parameter int SETTLE_CYC = 2,
  localparam int ID_W      = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_x,
  input  logic [N_REQ*WIDTH-1:0] req_y,
  input  logic [N_REQ-1:0]       req_op,
  output logic [WIDTH-1:0]       add_x,
  output logic [WIDTH-1:0]       add_y,
  output logic                   add_op,
  input  logic [WIDTH-1:0]       add_sum,
  input  logic                   add_cout,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_sum,
  output logic                   rsp_cout
);

  localparam int CNT_W = $clog2(SETTLE_CYC + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [ID_W:0] C_NREQ = (ID_W + 1)'(N_REQ);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  last_grant_q, last_grant_d;
  logic [WIDTH-1:0] add_x_q, add_x_d, add_y_q, add_y_d;
  logic             add_op_q, add_op_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_cout_q, rsp_cout_d;

  logic [WIDTH-1:0] x_arr [N_REQ];
  logic [WIDTH-1:0] y_arr [N_REQ];
  logic             grant_found;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W:0]    rr_sum;
  logic [ID_W-1:0]  rr_idx;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign x_arr[i] = req_x[i*WIDTH +: WIDTH];
    assign y_arr[i] = req_y[i*WIDTH +: WIDTH];
  end

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    rr_sum      = '0;
    rr_idx      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      rr_sum = {1'b0, last_grant_q} + (ID_W + 1)'(k);
      rr_idx = (rr_sum >= C_NREQ) ? ID_W'(rr_sum - C_NREQ) : ID_W'(rr_sum);
      if (!grant_found && req_valid[rr_idx]) begin
        grant_found = 1'b1;
        grant_id    = rr_idx;
      end
    end
  end

  assign req_ready = (state_q == IDLE && grant_found) ? (N_REQ'(1) << grant_id) : '0;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    add_x_d      = add_x_q;
    add_y_d      = add_y_q;
    add_op_d     = add_op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_sum_d    = rsp_sum_q;
    rsp_cout_d   = rsp_cout_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          add_x_d      = x_arr[grant_id];
          add_y_d      = y_arr[grant_id];
          add_op_d     = req_op[grant_id];
          rsp_id_d     = grant_id;
          last_grant_d = grant_id;
          cnt_d        = CNT_W'(SETTLE_CYC);
          state_d      = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rsp_sum_d   = add_sum;
          rsp_cout_d  = add_cout;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= ID_W'(N_REQ - 1);
      add_x_q      <= '0;
      add_y_q      <= '0;
      add_op_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_sum_q    <= '0;
      rsp_cout_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      add_x_q      <= add_x_d;
      add_y_q      <= add_y_d;
      add_op_q     <= add_op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_cout_q   <= rsp_cout_d;
    end
  end

  assign add_x     = add_x_q;
  assign add_y     = add_y_q;
  assign add_op    = add_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_share_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_adder_share_ctrl: directed bench with a behavioural shared adder.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_adder_share_ctrl;
  localparam int N = 4;
  localparam int W = 8;
  localparam int S = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_x = '0;
  logic [N*W-1:0] req_y = '0;
  logic [N-1:0]   req_op = '0;
  logic [W-1:0]   add_x, add_y, add_sum;
  logic           add_op, add_cout;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;

  int n_vec = 0;
  int n_err = 0;

  adder_share_ctrl #(.N_REQ(N), .WIDTH(W), .SETTLE_CYC(S)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_op(req_op),
    .add_x(add_x), .add_y(add_y), .add_op(add_op),
    .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
  );

  // The shared adder itself: subtraction is X + ~Y + 1, carry out = no borrow.
  assign {add_cout, add_sum} = add_op ? ({1'b0, add_x} + {1'b0, ~add_y} + 9'd1)
                                      : ({1'b0, add_x} + {1'b0, add_y});

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] x, input logic [W-1:0] y, input logic op);
    req_x[i*W +: W] = x;
    req_y[i*W +: W] = y;
    req_op[i]       = op;
    req_valid[i]    = 1'b1;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    #1;
    for (int c = 0; c < 32; c++) begin
      if (req_ready != '0) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 32; c++) begin
      if (rsp_valid === 1'b1) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0;
    tick();
    n_vec++; if ({add_x, add_y, add_op} !== '0) begin n_err++; $display("FAIL reset_add: got %h expected 0", {add_x, add_y, add_op}); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_vec++; if ({rsp_id, rsp_sum, rsp_cout} !== '0) begin n_err++; $display("FAIL reset_rsp: got %h expected 0", {rsp_id, rsp_sum, rsp_cout}); end
    n_vec++; if (req_ready !== '0) begin n_err++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_add();
    set_req(0, 8'd33, 8'd43, 1'b0);
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL add_grant: got %b expected 0001", req_ready); end
    tick();
    req_valid[0] = 1'b0;
    #1;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL add_ready_busy: got %b expected 0000", req_ready); end
    n_vec++; if ({add_x, add_y, add_op} !== {8'd33, 8'd43, 1'b0}) begin n_err++; $display("FAIL add_operands: got %0d %0d %b expected 33 43 0", add_x, add_y, add_op); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL add_early_valid1: got %b expected 0", rsp_valid); end
    tick();
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL add_early_valid2: got %b expected 0", rsp_valid); end
    tick();
    n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL add_latency: got %b expected 1", rsp_valid); end
    n_vec++; if ({rsp_id, rsp_sum, rsp_cout} !== {2'd0, 8'd76, 1'b0}) begin n_err++; $display("FAIL add_result: got id %0d sum %0d cout %b expected 0 76 0", rsp_id, rsp_sum, rsp_cout); end
    ack();
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL add_rsp_drop: got %b expected 0", rsp_valid); end
    n_vec++; if (rsp_sum !== 8'd76) begin n_err++; $display("FAIL add_sum_hold: got %0d expected 76", rsp_sum); end
  endtask

  task automatic test_subtract();
    bit ok;
    set_req(1, 8'd0, 8'd255, 1'b1);
    wait_ready(ok);
    n_vec++; if (!ok || req_ready !== 4'b0010) begin n_err++; $display("FAIL sub1_grant: got %b expected 0010", req_ready); end
    tick();
    req_valid = '0;
    wait_rsp(ok);
    n_vec++; if (!ok || {rsp_id, rsp_sum, rsp_cout} !== {2'd1, 8'd1, 1'b0}) begin n_err++; $display("FAIL sub1_result: got id %0d sum %0d cout %b expected 1 1 0", rsp_id, rsp_sum, rsp_cout); end
    ack();
    set_req(2, 8'd57, 8'd27, 1'b1);
    wait_ready(ok);
    n_vec++; if (!ok || req_ready !== 4'b0100) begin n_err++; $display("FAIL sub2_grant: got %b expected 0100", req_ready); end
    tick();
    req_valid = '0;
    wait_rsp(ok);
    n_vec++; if (!ok || {rsp_id, rsp_sum, rsp_cout} !== {2'd2, 8'd30, 1'b1}) begin n_err++; $display("FAIL sub2_result: got id %0d sum %0d cout %b expected 2 30 1", rsp_id, rsp_sum, rsp_cout); end
    ack();
  endtask

  task automatic test_all_valid();
    bit ok;
    logic [3:0] exp_rdy;
    logic [7:0] exp_sum [4] = '{8'd6, 8'd23, 8'd40, 8'd57};
    rst_n = 1'b0;
    tick();
    for (int i = 0; i < N; i++) set_req(i, 8'(i * 16 + 5), 8'(i + 1), 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      exp_rdy = 4'b0001 << i;
      wait_ready(ok);
      n_vec++; if (!ok || req_ready !== exp_rdy) begin n_err++; $display("FAIL all_grant%0d: got %b expected %b", i, req_ready, exp_rdy); end
      tick();
      req_valid[i] = 1'b0;
      wait_rsp(ok);
      n_vec++; if (!ok || rsp_id !== 2'(i) || rsp_sum !== exp_sum[i]) begin n_err++; $display("FAIL all_rsp%0d: got id %0d sum %0d expected %0d %0d", i, rsp_id, rsp_sum, i, exp_sum[i]); end
      ack();
    end
  endtask

  task automatic test_rr_order();
    bit ok;
    set_req(1, 8'd1, 8'd1, 1'b0);
    wait_ready(ok);
    tick();
    req_valid = '0;
    wait_rsp(ok);
    ack();
    set_req(0, 8'd10, 8'd20, 1'b0);
    set_req(3, 8'd250, 8'd10, 1'b0);
    wait_ready(ok);
    n_vec++; if (!ok || req_ready !== 4'b1000) begin n_err++; $display("FAIL rr_first: got %b expected 1000", req_ready); end
    tick();
    req_valid[3] = 1'b0;
    wait_rsp(ok);
    n_vec++; if (!ok || {rsp_id, rsp_sum, rsp_cout} !== {2'd3, 8'd4, 1'b1}) begin n_err++; $display("FAIL rr_rsp3: got id %0d sum %0d cout %b expected 3 4 1", rsp_id, rsp_sum, rsp_cout); end
    ack();
    wait_ready(ok);
    n_vec++; if (!ok || req_ready !== 4'b0001) begin n_err++; $display("FAIL rr_second: got %b expected 0001", req_ready); end
    tick();
    req_valid = '0;
    wait_rsp(ok);
    n_vec++; if (!ok || {rsp_id, rsp_sum} !== {2'd0, 8'd30}) begin n_err++; $display("FAIL rr_rsp0: got id %0d sum %0d expected 0 30", rsp_id, rsp_sum); end
    ack();
  endtask

  task automatic test_resp_stall();
    bit ok;
    set_req(2, 8'd100, 8'd50, 1'b0);
    wait_ready(ok);
    tick();
    req_valid = '0;
    wait_rsp(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL stall_rsp_timeout: got no rsp_valid expected 1"); end
    set_req(1, 8'd7, 8'd9, 1'b1);
    for (int c = 0; c < 5; c++) begin
      n_vec++; if ({rsp_valid, rsp_id, rsp_sum, rsp_cout} !== {1'b1, 2'd2, 8'd150, 1'b0}) begin n_err++; $display("FAIL stall_rsp_c%0d: got v%b id %0d sum %0d expected v1 2 150", c, rsp_valid, rsp_id, rsp_sum); end
      n_vec++; if (req_ready !== 4'b0000 || add_x !== 8'd100 || add_y !== 8'd50) begin n_err++; $display("FAIL stall_hold_c%0d: got rdy %b x %0d y %0d expected 0000 100 50", c, req_ready, add_x, add_y); end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL stall_no_same_cycle: got %b expected 0000", req_ready); end
    tick();
    rsp_ready = 1'b0;
    #1;
    n_vec++; if ({rsp_valid, rsp_sum, req_ready} !== {1'b0, 8'd150, 4'b0010}) begin n_err++; $display("FAIL stall_after_ack: got v%b sum %0d rdy %b expected v0 150 0010", rsp_valid, rsp_sum, req_ready); end
    tick();
    req_valid = '0;
    wait_rsp(ok);
    n_vec++; if (!ok || {rsp_id, rsp_sum, rsp_cout} !== {2'd1, 8'd254, 1'b0}) begin n_err++; $display("FAIL stall_next: got id %0d sum %0d cout %b expected 1 254 0", rsp_id, rsp_sum, rsp_cout); end
    ack();
  endtask

  task automatic test_reset_mid_busy();
    bit ok;
    bit seen;
    set_req(2, 8'd200, 8'd100, 1'b1);
    wait_ready(ok);
    tick();
    req_valid = '0;
    n_vec++; if (add_x !== 8'd200) begin n_err++; $display("FAIL midrst_pre: got %0d expected 200", add_x); end
    rst_n = 1'b0;
    #1;
    n_vec++; if ({add_x, add_y, add_op, rsp_valid, rsp_id, rsp_sum, rsp_cout, req_ready} !== '0) begin n_err++; $display("FAIL midrst_outputs: got %h expected 0", {add_x, add_y, add_op, rsp_valid, rsp_id, rsp_sum, rsp_cout}); end
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (rsp_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    n_vec++; if (seen) begin n_err++; $display("FAIL midrst_no_rsp: got rsp_valid 1 expected 0"); end
    set_req(0, 8'd3, 8'd4, 1'b0);
    set_req(1, 8'd5, 8'd6, 1'b0);
    set_req(3, 8'd7, 8'd8, 1'b0);
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL midrst_priority: got %b expected 0001", req_ready); end
    tick();
    req_valid = '0;
    wait_rsp(ok);
    n_vec++; if (!ok || {rsp_id, rsp_sum} !== {2'd0, 8'd7}) begin n_err++; $display("FAIL midrst_rsp: got id %0d sum %0d expected 0 7", rsp_id, rsp_sum); end
    ack();
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_subtract();
    test_all_valid();
    test_rr_order();
    test_resp_stall();
    test_reset_mid_busy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
